memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result, the destination register and the write-enable. Passes non-memory ops straight to writeback.
- Runs loads and stores against the data memory over a valid/ready request channel and a valid-only response channel.
- Stalls upstream through in_ready while a memory transaction is outstanding.

Parameters:
- WORD_SIZE, 32, datapath width. Only 32 is supported by the byte-lane logic.
- STRB_WIDTH, WORD_SIZE/8, byte-strobe width. Derived; not to be overridden.

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream op valid this cycle
- in_ready  out  1  stage can accept an op; equals (state==IDLE)
- alu_result  in  WORD_SIZE  ALU output; the effective address for memory ops
- store_data  in  WORD_SIZE  rs2 value for stores
- mem_read  in  1  op is a load
- mem_write  in  1  op is a store
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- reg_dest_in  in  5  destination register
- write_enable_in  in  1  op writes the register file
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1=store, 0=load
- dmem_addr  out  WORD_SIZE  word-aligned address, {alu_result[31:2],2'b00}
- dmem_wdata  out  WORD_SIZE  store data, lane-replicated
- dmem_wstrb  out  STRB_WIDTH  byte enables
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  WORD_SIZE  load data word
- wb_valid  out  1  one-cycle pulse: result ready for writeback
- wb_data  out  WORD_SIZE  writeback value
- wb_reg_dest  out  5  destination register
- wb_write_enable  out  1  register-file write enable

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - All outputs become 0 except in_ready, which is 1.
  - Any request in flight is abandoned and dmem_req_valid drops immediately.
- FSM states: IDLE, REQ, WAIT_RSP.
- Accept: an op is accepted at the edge where in_valid && in_ready.
  - Op, address, data, funct3 and dest are captured into internal registers.
- Non-memory op, accepted at edge N:
  - wb_data=alu_result, wb_reg_dest=reg_dest_in, wb_write_enable=write_enable_in.
  - wb_valid is high for exactly the cycle after N.
  - State stays IDLE, so a new op can be accepted every cycle: 1-cycle latency, full throughput.
- Memory op, accepted at edge N:
  - State goes to REQ.
  - dmem_req_valid, dmem_req_we, dmem_addr, dmem_wdata and dmem_wstrb are registered and stable from cycle N+1 until the handshake.
- Priority: if mem_read and mem_write are both set, the op is treated as a load.
- REQ state:
  - Stays in REQ while !dmem_req_ready.
  - At the handshake edge, a store pulses wb_valid with wb_write_enable=0 and returns to IDLE.
  - At the handshake edge, a load goes to WAIT_RSP.
  - dmem_req_valid drops in the cycle after the handshake.
- WAIT_RSP state:
  - At the edge where dmem_rsp_valid is high: the byte/half is extracted at offset alu_result[1:0] and sign- or zero-extended per funct3.
  - wb_valid pulses with wb_write_enable=write_enable_in, and the state returns to IDLE.
  - dmem_rsp_valid is ignored in any other state.
- Minimum latencies:
  - Store: handshake in cycle N+1, wb_valid in cycle N+2.
  - Load: response in cycle N+2, wb_valid in cycle N+3.
- Store strobes:
  - SB: 4'b0001<<addr[1:0], wdata = byte replicated x4.
  - SH: 4'b0011<<{addr[1],1'b0}, wdata = half replicated x2.
  - SW: 4'hF.
- Load extraction:
  - LH/LHU select the half by addr[1] and ignore addr[0].
  - LW ignores addr[1:0].
- wb_reg_dest==0 always forces wb_write_enable=0.
- wb_data, wb_reg_dest and wb_write_enable hold their last value when wb_valid=0.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - Adds output mem_fault (1 bit, reset 0).
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, issues no dmem request and stays IDLE.
  - In the cycle after accept it pulses wb_valid and mem_fault together, with wb_write_enable=0 and wb_data=alu_result (the faulting address).
- Undefined: no port is added, and misaligned addresses are silently aligned as described in Behaviour.

Test Plan:
- ALU passthrough: 3 back-to-back ops (alu_result=5,6,7; dest=1,2,3; we=1) -> wb_valid high 3 consecutive cycles carrying 5,6,7 with dests 1,2,3; in_ready stays 1.
- LB sign-extend: addr=0x1003, dmem_rdata=0x80AABBCC -> dmem_addr=0x1000; wb_data=0xFFFFFF80, wb_write_enable=1, wb_valid 3 cycles after accept.
- SH lane: addr=0x2002, store_data=0x1234ABCD -> dmem_wstrb=4'b1100, dmem_wdata=0xABCDABCD, dmem_req_we=1; wb_valid with wb_write_enable=0.
- Backpressure: LHU at 0x0, req_ready low 4 cycles, rsp 2 cycles after handshake, rdata=0x0000F00D -> req signals stable throughout; wb_data=0x0000F00D; in_ready=0 from the accept edge until the return to IDLE; in_valid ignored meanwhile.
- Reset in WAIT_RSP: reset_n low for 1 cycle, then a late dmem_rsp_valid arrives -> dmem_req_valid=0 and wb_valid=0 immediately; the late response produces no wb_valid; in_ready=1.
- With MEM_MISALIGN_CHECK_EN defined: LW at 0x3001 -> dmem_req_valid never asserts; mem_fault=1 and wb_valid=1 in the cycle after accept with wb_data=0x3001 and wb_write_enable=0.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage; loads/stores over a valid/ready request and valid-only response channel.
// Optional MEM_MISALIGN_CHECK_EN adds mem_fault and turns misaligned H/W accesses into faults.
module memory_access #(
  parameter int WORD_SIZE  = 32,
  parameter int STRB_WIDTH = WORD_SIZE / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  alu_result,
  input  logic [WORD_SIZE-1:0]  store_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [4:0]            reg_dest_in,
  input  logic                  write_enable_in,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [WORD_SIZE-1:0]  dmem_addr,
  output logic [WORD_SIZE-1:0]  dmem_wdata,
  output logic [STRB_WIDTH-1:0] dmem_wstrb,
  input  logic                  dmem_rsp_valid,
  input  logic [WORD_SIZE-1:0]  dmem_rdata,
  output logic                  wb_valid,
  output logic [WORD_SIZE-1:0]  wb_data,
  output logic [4:0]            wb_reg_dest,
  output logic                  wb_write_enable
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic                  mem_fault
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
  state_t state, state_next;
  logic op_load, we_q, accept, is_mem, misalign;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic [4:0] dest_q;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [WORD_SIZE-1:0] load_val, st_wdata;
  logic [STRB_WIDTH-1:0] st_strb;
  assign in_ready = state == IDLE;
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_read || mem_write;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = is_mem && ((funct3[1:0] == 2'b01 && alu_result[0]) ||
                               (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  always_comb begin
    rbyte    = dmem_rdata[{off_q, 3'b000} +: 8];
    rhalf    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_val = f3_q[1] ? dmem_rdata :
               f3_q[0] ? {{16{rhalf[15] & ~f3_q[2]}}, rhalf} :
                         {{24{rbyte[7] & ~f3_q[2]}}, rbyte};
    st_strb  = funct3[1:0] == 2'b00 ? 4'b0001 << alu_result[1:0] :
               funct3[1:0] == 2'b01 ? 4'b0011 << {alu_result[1], 1'b0} : 4'hF;
    st_wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
               funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
  end
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (accept && is_mem && !misalign) state_next = REQ;
      REQ:      if (dmem_req_ready) state_next = op_load ? WAIT_RSP : IDLE;
      WAIT_RSP: if (dmem_rsp_valid) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_load         <= 1'b0;
      we_q            <= 1'b0;
      off_q           <= '0;
      f3_q            <= '0;
      dest_q          <= '0;
      dmem_req_valid  <= 1'b0;
      dmem_req_we     <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      dmem_wstrb      <= '0;
      wb_valid        <= 1'b0;
      wb_data         <= '0;
      wb_reg_dest     <= '0;
      wb_write_enable <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      mem_fault       <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      mem_fault <= 1'b0;
`endif
      if (accept) begin
        op_load <= mem_read;
        we_q    <= write_enable_in;
        off_q   <= alu_result[1:0];
        f3_q    <= funct3;
        dest_q  <= reg_dest_in;
        if (!is_mem || misalign) begin
          wb_valid        <= 1'b1;
          wb_data         <= alu_result;
          wb_reg_dest     <= reg_dest_in;
          wb_write_enable <= !is_mem && write_enable_in && |reg_dest_in;
`ifdef MEM_MISALIGN_CHECK_EN
          mem_fault       <= is_mem;
`endif
        end else begin
          dmem_req_valid <= 1'b1;
          dmem_req_we    <= !mem_read;
          dmem_addr      <= {alu_result[WORD_SIZE-1:2], 2'b00};
          dmem_wdata     <= st_wdata;
          dmem_wstrb     <= st_strb;
        end
      end
      if (state == REQ && dmem_req_ready) begin
        dmem_req_valid <= 1'b0;
        if (!op_load) begin
          wb_valid        <= 1'b1;
          wb_reg_dest     <= dest_q;
          wb_write_enable <= 1'b0;
        end
      end
      if (state == WAIT_RSP && dmem_rsp_valid) begin
        wb_valid        <= 1'b1;
        wb_data         <= load_val;
        wb_reg_dest     <= dest_q;
        wb_write_enable <= we_q && |dest_q;
      end
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed plus randomized checks of memory_access against an arithmetic reference model.
module tb_memory_access;
  logic clock = 1'b0, reset_n = 1'b0;
  logic in_valid = 0, in_ready, mem_read = 0, mem_write = 0, write_enable_in = 0;
  logic [31:0] alu_result = 0, store_data = 0, dmem_addr, dmem_wdata, dmem_rdata = 0, wb_data;
  logic [2:0] funct3 = 0;
  logic [4:0] reg_dest_in = 0, wb_reg_dest;
  logic dmem_req_valid, dmem_req_ready = 0, dmem_req_we, dmem_rsp_valid = 0, wb_valid, wb_write_enable;
  logic [3:0] dmem_wstrb;
`ifdef MEM_MISALIGN_CHECK_EN
  logic mem_fault;
`endif
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  memory_access dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .reg_dest_in(reg_dest_in), .write_enable_in(write_enable_in),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_reg_dest(wb_reg_dest), .wb_write_enable(wb_write_enable)
`ifdef MEM_MISALIGN_CHECK_EN
    , .mem_fault(mem_fault)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int unsigned m_size(input logic [2:0] f3);
    int unsigned s = f3 % 4;
    return s == 0 ? 1 : s == 1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdw);
    int unsigned n = m_size(f3), v;
    bit sgn = f3 < 4;
    if (n == 4) return rdw;
    v = (rdw >> (8 * n * ((a % 4) / n))) & ((32'd1 << (8 * n)) - 1);
    if (sgn && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction
  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n = m_size(f3);
    return 4'(((32'd1 << n) - 1) << ((a % 4) / n * n));
  endfunction
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int unsigned n = m_size(f3);
    logic [31:0] w = 0, part;
    if (n == 4) return sd;
    part = sd & ((32'd1 << (8 * n)) - 1);
    for (int k = 0; k < 4 / n; k++) w = w | (part << (8 * n * k));
    return w;
  endfunction
  function automatic bit m_misalign(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    return m_size(f3) > 1 && (a % m_size(f3)) != 0;
`else
    return 0;
`endif
  endfunction
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] dest, input bit we,
                       input logic [31:0] rdw, input int req_lat, input int rsp_lat, input string tag);
    bit mem = rd || wr;
    chk({tag, ".in_ready_pre"}, in_ready, 1);
    in_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a;
    store_data = sd; reg_dest_in = dest; write_enable_in = we;
    @(posedge clock); #1;
    in_valid = mem; alu_result = $urandom; store_data = $urandom; reg_dest_in = 5'($urandom);
    if (!mem || m_misalign(f3, a)) begin
      in_valid = 0;
      chk({tag, ".wb_valid"}, wb_valid, 1);
      chk({tag, ".wb_data"}, wb_data, a);
      chk({tag, ".wb_dest"}, wb_reg_dest, dest);
      chk({tag, ".wb_we"}, wb_write_enable, !mem && we && dest != 0);
      chk({tag, ".req_idle"}, dmem_req_valid, 0);
`ifdef MEM_MISALIGN_CHECK_EN
      chk({tag, ".fault"}, mem_fault, mem);
`endif
      return;
    end
    for (int i = 0; i <= req_lat; i++) begin
      dmem_req_ready = (i == req_lat);
      dmem_rsp_valid = 1'($urandom);
      chk({tag, ".req_valid"}, dmem_req_valid, 1);
      chk({tag, ".req_we"}, dmem_req_we, !rd);
      chk({tag, ".req_addr"}, dmem_addr, a & 32'hFFFF_FFFC);
      if (!rd) chk({tag, ".wstrb"}, dmem_wstrb, m_strb(f3, a));
      if (!rd) chk({tag, ".wdata"}, dmem_wdata, m_wdata(f3, sd));
      chk({tag, ".busy"}, in_ready, 0);
      chk({tag, ".no_wb"}, wb_valid, 0);
      @(posedge clock); #1;
    end
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    chk({tag, ".req_drop"}, dmem_req_valid, 0);
    if (!rd) begin
      in_valid = 0;
      chk({tag, ".st_wb_valid"}, wb_valid, 1);
      chk({tag, ".st_wb_we"}, wb_write_enable, 0);
      chk({tag, ".st_ready"}, in_ready, 1);
      return;
    end
    chk({tag, ".wait_busy"}, in_ready, 0);
    chk({tag, ".wait_no_wb"}, wb_valid, 0);
    for (int i = 0; i <= rsp_lat; i++) begin
      dmem_rsp_valid = (i == rsp_lat);
      dmem_rdata = (i == rsp_lat) ? rdw : $urandom;
      @(posedge clock); #1;
      if (i < rsp_lat) chk({tag, ".rsp_wait"}, wb_valid, 0);
    end
    dmem_rsp_valid = 0; in_valid = 0;
    chk({tag, ".ld_wb_valid"}, wb_valid, 1);
    chk({tag, ".ld_wb_data"}, wb_data, m_load(f3, a, rdw));
    chk({tag, ".ld_wb_dest"}, wb_reg_dest, dest);
    chk({tag, ".ld_wb_we"}, wb_write_enable, we && dest != 0);
    chk({tag, ".ld_ready"}, in_ready, 1);
  endtask
  initial begin
    #500000;
    $fatal(1, "FAIL watchdog timeout");
  end
  initial begin
    logic [2:0] lf3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] held;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.req_valid", dmem_req_valid, 0);
    chk("rst.wb_valid", wb_valid, 0);
    chk("rst.wb_data", wb_data, 0);
    chk("rst.wstrb", dmem_wstrb, 0);
    reset_n = 1;
    @(posedge clock); #1;
    do_op(0, 0, 0, 5, 0, 1, 1, 0, 0, 0, "alu0");
    do_op(0, 0, 0, 6, 0, 2, 1, 0, 0, 0, "alu1");
    do_op(0, 0, 0, 7, 0, 3, 1, 0, 0, 0, "alu2");
    do_op(0, 0, 0, 9, 0, 0, 1, 0, 0, 0, "alu_x0");
    do_op(1, 0, 3'b000, 32'h1003, 0, 4, 1, 32'h80AA_BBCC, 0, 0, "lb");
    held = wb_data;
    @(posedge clock); #1;
    chk("hold.wb_valid", wb_valid, 0);
    chk("hold.wb_data", wb_data, held);
    do_op(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 5, 1, 0, 0, 0, "sh");
    do_op(1, 0, 3'b101, 32'h0, 0, 6, 1, 32'h0000_F00D, 4, 1, "lhu_bp");
    do_op(1, 1, 3'b010, 32'h40, 32'hDEAD_BEEF, 7, 1, 32'h1357_9BDF, 1, 2, "both_is_load");
`ifdef MEM_MISALIGN_CHECK_EN
    do_op(1, 0, 3'b010, 32'h3001, 0, 8, 1, 0, 0, 0, "lw_misalign");
`endif
    in_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; alu_result = 32'h100;
    @(posedge clock); #1;
    in_valid = 0;
    chk("rst_req.pre", dmem_req_valid, 1);
    #2 reset_n = 0;
    #1;
    chk("rst_req.req_valid", dmem_req_valid, 0);
    chk("rst_req.in_ready", in_ready, 1);
    @(posedge clock); #1 reset_n = 1;
    in_valid = 1; mem_read = 1; alu_result = 32'h200; dmem_req_ready = 1;
    @(posedge clock); #1;
    in_valid = 0;
    @(posedge clock); #1;
    dmem_req_ready = 0;
    chk("rst_wait.pre", in_ready, 0);
    #2 reset_n = 0;
    #1;
    chk("rst_wait.req_valid", dmem_req_valid, 0);
    chk("rst_wait.wb_valid", wb_valid, 0);
    chk("rst_wait.in_ready", in_ready, 1);
    @(posedge clock); #1 reset_n = 1;
    dmem_rsp_valid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    dmem_rsp_valid = 0;
    chk("late_rsp.wb_valid", wb_valid, 0);
    chk("late_rsp.in_ready", in_ready, 1);
    for (int n = 0; n < 80; n++) begin
      int kind = $urandom_range(0, 9);
      logic [2:0] f3 = lf3[$urandom_range(0, 4)];
      if (kind < 4) do_op(0, 0, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0, 0, "rnd_alu");
      else if (kind < 7) do_op(1, 1'($urandom), f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
                               $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rnd_ld");
      else do_op(0, 1, 3'($urandom_range(0, 2)), $urandom, $urandom, 5'($urandom), 1'($urandom),
                 0, $urandom_range(0, 3), 0, "rnd_st");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
        chk("rnd.idle_wb", wb_valid, 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
